instr_fetch: RTL and testbench

//  Instruction fetch sequencer, the consumer side of the program counter. Reads the current
//  PC, fetches the opcode and operand words from program memory over a req/ack port, and

---
 rtl/instr_fetch.sv | 99 +++++++++
 tb/tb_instr_fetch.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads opcode/operand pairs for the current PC over a
// req/ack memory port, holds them for execute, then pulses pc_enable once per instruction.
module instr_fetch #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_enable,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  pc_enable,
    output logic                  mem_req,
    output logic [DATA_WIDTH:0]   mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  instr_valid,
    input  logic                  exec_done,
    output logic                  fetch_err,
    output logic [DATA_WIDTH-1:0] instr_count,
    output logic [2:0]            fetch_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_OP  = 3'd1,
        S_FETCH_ARG = 3'd2,
        S_ISSUE     = 3'd3,
        S_ADVANCE   = 3'd4,
        S_ERROR     = 3'd5
    } state_e;

    // wait_q counts missed-ack cycles 0..ACK_TIMEOUT-1; the last one trips the error
    localparam int WCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_e                  state_q, state_d;
    logic [WCW-1:0]          wait_q;
    logic [DATA_WIDTH:0]     addr_q;
    logic [DATA_WIDTH-1:0]   opcode_q, operand_q, count_q;
    logic                    mem_req_q, instr_valid_q, pc_enable_q, fetch_err_q;
    logic                    in_fetch, timeout;

    always_comb begin
        state_d  = state_q;
        in_fetch = (state_q == S_FETCH_OP) || (state_q == S_FETCH_ARG);
        timeout  = in_fetch && !mem_ack && (ACK_TIMEOUT != 0) && (wait_q == WAIT_LAST);
        case (state_q)
            S_IDLE:      if (fetch_enable) state_d = S_FETCH_OP;
            S_FETCH_OP:  if (mem_ack) state_d = S_FETCH_ARG;
                         else if (timeout) state_d = S_ERROR;
            S_FETCH_ARG: if (mem_ack) state_d = S_ISSUE;
                         else if (timeout) state_d = S_ERROR;
            S_ISSUE:     if (exec_done) state_d = S_ADVANCE;
            S_ADVANCE:   state_d = fetch_enable ? S_FETCH_OP : S_IDLE;
            S_ERROR:     state_d = S_ERROR;
            default:     state_d = S_IDLE;
        endcase
        // pc is live during fetch so the post-branch PC is used in the first fetch cycle
        mem_addr = in_fetch ? {pc, state_q == S_FETCH_ARG} : addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            addr_q        <= '0;
            opcode_q      <= '0;
            operand_q     <= '0;
            count_q       <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            pc_enable_q   <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= (state_d == S_FETCH_OP) || (state_d == S_FETCH_ARG);
            instr_valid_q <= (state_d == S_ISSUE);
            pc_enable_q   <= (state_d == S_ADVANCE);
            if (state_d == S_ERROR) fetch_err_q <= 1'b1;
            wait_q        <= (in_fetch && !mem_ack) ? wait_q + WCW'(1) : '0;
            if (in_fetch) addr_q <= mem_addr;
            if (state_q == S_FETCH_OP && mem_ack) opcode_q <= mem_rdata;
            if (state_q == S_FETCH_ARG && mem_ack) operand_q <= mem_rdata;
            if (state_q == S_ADVANCE) count_q <= count_q + DATA_WIDTH'(1);
        end
    end

    assign pc_enable   = pc_enable_q;
    assign mem_req     = mem_req_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;
    assign instr_count = count_q;
    assign fetch_state = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a thread-style reference model walks each instruction
// (fetch word, fetch word, wait execute, retire) and one negedge process compares every cycle.
module tb_instr_fetch;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0, reset = 1'b0, fetch_enable = 1'b0, mem_ack = 1'b0, exec_done = 1'b0;
    logic [DW-1:0] pc = '0, mem_rdata = '0;
    logic          pc_enable, mem_req, instr_valid, fetch_err;
    logic [DW:0]   mem_addr;
    logic [DW-1:0] opcode, operand, instr_count;
    logic [2:0]    fetch_state;

    instr_fetch #(.DATA_WIDTH(DW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable), .pc(pc), .pc_enable(pc_enable),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .opcode(opcode), .operand(operand), .instr_valid(instr_valid), .exec_done(exec_done),
        .fetch_err(fetch_err), .instr_count(instr_count), .fetch_state(fetch_state)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit chk_en = 0;
    int mode = 0;       // memory: 0 zero-wait, 1 random latency, 2 never acks a request
    bit pc_branch = 0;  // PC update: increment or occasional random branch

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [DW:0] a);
        if (a == 0) return 8'h70;
        if (a == 1) return 8'h42;
        return DW'((a * 37) ^ (a >> 3) ^ 9'h05A);
    endfunction

    // ---------------- reference model ----------------
    int            epoch = 0;
    logic [2:0]    e_state = 0;
    logic          e_req = 0, e_slot = 0, e_valid = 0, e_pce = 0, e_err = 0;
    logic [DW:0]   e_hold = 0;
    logic [DW-1:0] e_op = 0, e_arg = 0, e_cnt = 0;

    always @(negedge reset) begin
        epoch++;
        e_state = 0; e_req = 0; e_slot = 0; e_valid = 0; e_pce = 0; e_err = 0;
        e_hold = 0; e_op = 0; e_arg = 0; e_cnt = 0;
    end

    // st: 0 = word read, 1 = timed out, 2 = aborted by reset
    task automatic fetch_word(input int ep, input bit slot, output int st);
        int waits = 0;
        e_state = slot ? 3'd2 : 3'd1; e_req = 1; e_slot = slot; e_valid = 0; e_pce = 0;
        forever begin
            @(posedge clk);
            if (ep != epoch) begin st = 2; return; end
            e_hold = {pc, slot};
            if (mem_ack) begin
                if (slot) e_arg = mem_rdata; else e_op = mem_rdata;
                st = 0; return;
            end
            waits++;
            if (TO > 0 && waits == TO) begin st = 1; return; end
        end
    endtask

    task automatic model_body(input int ep);
        int st;
        bit go;
        forever begin
            e_state = 0; e_req = 0; e_valid = 0; e_pce = 0;
            go = 0;
            while (!go) begin
                @(posedge clk);
                if (ep != epoch) return;
                go = fetch_enable;
            end
            while (go) begin
                for (int s = 0; s < 2; s++) begin
                    fetch_word(ep, s[0], st);
                    if (st == 2) return;
                    if (st == 1) begin
                        e_state = 5; e_req = 0; e_err = 1;
                        forever begin @(posedge clk); if (ep != epoch) return; end
                    end
                end
                e_state = 3; e_req = 0; e_valid = 1;
                do begin
                    @(posedge clk);
                    if (ep != epoch) return;
                end while (!exec_done);
                e_state = 4; e_valid = 0; e_pce = 1;
                @(posedge clk);
                if (ep != epoch) return;
                e_cnt = e_cnt + 1'b1; e_pce = 0;
                go = fetch_enable;
            end
        end
    endtask

    initial forever begin
        wait (reset === 1'b1);
        model_body(epoch);
    end

    always @(negedge clk) if (chk_en) begin
        chk("state", fetch_state, e_state);
        chk("mem_req", mem_req, e_req);
        chk("mem_addr", mem_addr, e_req ? {pc, e_slot} : e_hold);
        chk("instr_valid", instr_valid, e_valid);
        chk("pc_enable", pc_enable, e_pce);
        chk("fetch_err", fetch_err, e_err);
        chk("opcode", opcode, e_op);
        chk("operand", operand, e_arg);
        chk("instr_count", instr_count, e_cnt);
    end

    // ---------------- environment: memory and PC ----------------
    int pend = -1;
    always @(negedge clk) begin
        if (mem_req && mode != 2) begin
            if (pend < 0) begin
                if (mode == 0) pend = 0;
                else case ($urandom_range(0, 63))
                    50, 51, 52, 53: pend = 1;
                    54, 55:         pend = 2;
                    56, 57:         pend = 3;
                    58, 59:         pend = 6;
                    60, 61:         pend = 7;
                    62, 63:         pend = 8;
                    default:        pend = 0;
                endcase
            end
            if (pend == 0) begin
                mem_ack = 1; mem_rdata = mem_word(mem_addr); pend = -1;
            end else begin
                mem_ack = 0; mem_rdata = DW'($urandom); pend--;
            end
        end else begin
            pend = -1;
            mem_ack = !mem_req && ($urandom_range(0, 3) == 0);
            mem_rdata = DW'($urandom);
        end
    end

    logic pce_seen = 0;
    always @(negedge clk) pce_seen = pc_enable;
    always @(posedge clk) begin
        #1;
        if (pce_seen) pc = (pc_branch && $urandom_range(0, 3) == 0) ? DW'($urandom) : pc + 1'b1;
    end

    // ---------------- directed helpers ----------------
    task automatic rst_zero_checks(input string tag);
        chk({tag, ".state"}, fetch_state, 0);
        chk({tag, ".mem_req"}, mem_req, 0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".opcode"}, opcode, 0);
        chk({tag, ".operand"}, operand, 0);
        chk({tag, ".valid"}, instr_valid, 0);
        chk({tag, ".pc_enable"}, pc_enable, 0);
        chk({tag, ".fetch_err"}, fetch_err, 0);
        chk({tag, ".count"}, instr_count, 0);
    endtask

    // asynchronous reset applied between edges, checked before the next edge
    task automatic async_reset(input string tag);
        @(posedge clk); #2 reset = 0;
        #1 rst_zero_checks(tag);
        @(posedge clk);
        @(negedge clk); #1 reset = 1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
        int n = 0;
        while (fetch_state !== s && n < lim) begin @(negedge clk); n++; end
        if (fetch_state !== s) begin
            total++; bad++;
            $display("FAIL %s: state %0d never reached within %0d cycles", tag, s, lim);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst_zero_checks("reset");
        chk_en = 1;

        // zero-wait memory, execute always done: 4-cycle instruction
        exec_done = 1; fetch_enable = 1; reset = 1;
        @(negedge clk); chk("t1.state0", fetch_state, 1); chk("t1.addr0", mem_addr, 9'h000);
        @(negedge clk); chk("t1.state1", fetch_state, 2); chk("t1.addr1", mem_addr, 9'h001);
                        chk("t1.opcode", opcode, 8'h70);
        @(negedge clk); chk("t1.state2", fetch_state, 3); chk("t1.valid", instr_valid, 1);
                        chk("t1.operand", operand, 8'h42);
        @(negedge clk); chk("t1.state3", fetch_state, 4); chk("t1.pce", pc_enable, 1);
        @(negedge clk); chk("t1.state4", fetch_state, 1); chk("t1.addr2", mem_addr, 9'h002);
                        chk("t1.count", instr_count, 1);

        // randomized run, starting near the PC wrap
        pc = 8'hFD; mode = 1; pc_branch = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            fetch_enable = ($urandom_range(0, 7) != 0);
            exec_done = $urandom_range(0, 1);
            if (fetch_err || $urandom_range(0, 299) == 0) async_reset("rnd_rst");
        end

        // timeout: no ack ever, exactly TO cycles in FETCH_OP, then stuck in ERROR
        async_reset("pre_to");
        mode = 2; fetch_enable = 1; pc_branch = 0;
        wait_state(1, 10, "to.enter");
        n = 0;
        while (fetch_state === 3'd1 && n < 50) begin @(negedge clk); n++; end
        chk("to.cycles", n, TO);
        chk("to.state", fetch_state, 5);
        chk("to.err", fetch_err, 1);
        chk("to.req", mem_req, 0);
        repeat (10) @(negedge clk);
        chk("to.stuck", fetch_state, 5);
        async_reset("to_clear");

        // reset in the middle of FETCH_ARG, restart from {pc,0}
        mode = 0; fetch_enable = 1; exec_done = 0;
        wait_state(2, 10, "mid.arg");
        async_reset("mid_arg");
        @(negedge clk);
        chk("mid.restart_state", fetch_state, 1);
        chk("mid.restart_addr", mem_addr, {pc, 1'b0});

        // retire 255 instructions, then drop fetch_enable during the 256th ISSUE
        async_reset("pre_wrap");
        exec_done = 1; fetch_enable = 1;
        n = 0;
        for (int c = 0; c < 2000 && n < 255; c++) begin
            @(negedge clk);
            if (pc_enable) n++;
        end
        chk("wrap.pulses", n, 255);
        wait_state(3, 10, "wrap.issue");
        fetch_enable = 0;
        @(negedge clk); chk("wrap.pce", pc_enable, 1); chk("wrap.count_ff", instr_count, 8'hFF);
        @(negedge clk); chk("wrap.idle", fetch_state, 0); chk("wrap.count_0", instr_count, 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("wrap.noreq", mem_req, 0);
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
